shift_rotate_unit: RTL and testbench
====================================

Name: shift_rotate_unit

Overview:
- Parametrised, pipelined shift/rotate execution unit; the successor to the fixed 16-bit combinational right-rotator.
- Supports five operations with any width N (power of two), status flags, and a valid/ready handshake with backpressure.
- Sits in the processor ALU datapath between operand fetch and writeback.
- Two-stage pipeline:
  - S1 registers the operands.
  - S2 registers the computed result and flags.

Parameters:
- N, 16, data width; must be a power of two, at least 2.
- SW, 4, shift-amount width; must equal log2(N).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  unit can accept a beat this cycle
- in_data  in  N  operand
- in_amt  in  SW  shift amount, 0..N-1
- in_op  in  3  operation select: 000 ROR, 001 ROL, 010 LSR, 011 LSL, 100 ASR
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  N  result
- out_carry  out  1  last bit shifted or rotated out
- out_zero  out  1  out_data == 0
- out_err  out  1  in_op was 101/110/111

Behaviour:
- Reset values, applied at the clock edge while reset=1:
  - s1_valid=0, s2_valid=0, out_valid=0.
  - out_data=0, out_carry=0, out_zero=0, out_err=0.
  - S1 data registers go to 0.
- Reset has priority over every other event. Any beats in flight are discarded without being emitted.
- Handshake rules:
  - A beat transfers when valid & ready are both high on the same rising edge.
  - Producer and consumer hold their signals stable while valid=1 and ready=0.
- Pipeline advance:
  - s2_adv = ~s2_valid | out_ready
  - s1_adv = ~s1_valid | s2_adv
  - in_ready = s1_adv. This is combinational, and has no path from in_valid.
- Latency: a beat accepted at edge k appears on out_valid/out_data after edge k+2, provided there is no stall.
- Throughput: one beat per cycle when out_ready is held at 1.
- Capacity: 2 beats maximum. With out_ready=0 and both stages full, in_ready=0.
- Ordering: beats leave in acceptance order; none is dropped or duplicated.
- Outputs are registered in S2 and stay stable while out_valid=1 and out_ready=0.
- Result computed from the S1 operand d, amount a, and op:
  - ROR: out = d rotated right by a.
  - ROL: out = d rotated left by a.
  - LSR: out = d >> a, zero fill.
  - LSL: out = d << a, zero fill.
  - ASR: out = d >> a, filled with d[N-1].
- Carry (out_carry):
  - a=0: carry=0 for every op.
  - ROR: carry = out[N-1].
  - ROL: carry = out[0].
  - LSR and ASR: carry = d[a-1].
  - LSL: carry = d[N-a].
- Illegal op (101/110/111): out=d, carry=0, err=1. For legal ops err=0.
- out_zero is computed from the result, including pass-through results.
- in_amt is always treated modulo N; no masking is needed because SW=log2(N).
- Rotate by 0 is identity.
- Simultaneous events with full stages: when out_ready=1 and in_valid=1, S2 drains, S1 moves to S2, and the new beat enters S1 on the same edge.

Test Plan (N=16):
1. Single-op checks, sent one at a time:
   - ROR 0x0001 by 1 -> 0x8000, carry=1, zero=0, out_valid exactly 2 cycles after acceptance.
   - ROL 0x8001 by 4 -> 0x0018, carry=0.
   - LSL 0x8001 by 1 -> 0x0002, carry=1.
   - LSR 0x00F0 by 4 -> 0x000F, carry=0.
   - ASR 0x8000 by 15 -> 0xFFFF, carry=0.
   - LSR 0x0001 by 1 -> 0x0000, carry=1, zero=1.
2. Amount 0 and illegal op:
   - ROR 0xA5A5 by 0 -> 0xA5A5, carry=0.
   - op=111 on 0x1234 -> 0x1234, err=1.
   - The next legal op -> err=0.
3. Backpressure:
   - Hold out_ready=0 and offer 3 beats.
   - Required: first two accepted, in_ready=0 for the third.
   - Required: out_data stays stable.
   - Release out_ready: all 3 results emerge in order, with no gaps once streaming.
4. Streaming: 32 random beats back-to-back with out_ready=1 -> one result per cycle, matching a software model. Include every op and every amount 0..15.
5. Reset mid-operation:
   - Assert reset for 1 cycle while both stages are full.
   - Next cycle: out_valid=0, out_data=0, in_ready=1.
   - No stale beat is emitted afterwards.
6. Random out_ready toggling (50%), 200 beats -> scoreboard shows no loss, no duplication, and order preserved.

Source files
------------

// File: rtl/shift_rotate_if.sv
// Operand/result handshake bundle for the shift/rotate unit.
// The unit itself uses the slave modport; the producer/consumer side uses master.
interface shift_rotate_if #(
  parameter int N  = 16,
  parameter int SW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic [SW-1:0] in_amt;
  logic [2:0]    in_op;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;
  logic          out_carry;
  logic          out_zero;
  logic          out_err;

  modport master (
    output in_valid, in_data, in_amt, in_op, out_ready,
    input  in_ready, out_valid, out_data, out_carry, out_zero, out_err
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_op, out_ready,
    output in_ready, out_valid, out_data, out_carry, out_zero, out_err
  );
endinterface

// File: rtl/shift_rotate_unit.sv
// Two-stage shift/rotate execution unit: S1 holds operands, S2 holds the
// result and flags. Stages advance independently so a full pipe still streams.
module shift_rotate_unit #(
  parameter int N  = 16,
  parameter int SW = 4
) (
  input logic           clk,
  input logic           reset,
  shift_rotate_if.slave bus
);

  typedef struct packed {
    logic         err;
    logic         carry;
    logic [N-1:0] data;
  } res_t;

  // Carry is the last bit leaving the word, taken from the operand at a-1
  // (right shifts) or N-a (left shift) by shifting one position short.
  function automatic res_t compute(input logic [N-1:0] d, input logic [SW-1:0] a,
                                   input logic [2:0] op);
    res_t         r;
    logic [2*N-1:0] dd;
    logic [N-1:0] sh;
    logic [SW-1:0] am1;
    logic         nz;
    dd      = {d, d};
    am1     = a - {{(SW-1){1'b0}}, 1'b1};
    nz      = (a != {SW{1'b0}});
    r.err   = 1'b0;
    r.carry = 1'b0;
    r.data  = d;
    sh      = {N{1'b0}};
    case (op)
      3'b000: begin
        dd      = dd >> a;
        r.data  = dd[N-1:0];
        r.carry = nz & r.data[N-1];
      end
      3'b001: begin
        dd      = dd << a;
        r.data  = dd[2*N-1:N];
        r.carry = nz & r.data[0];
      end
      3'b010: begin
        r.data  = d >> a;
        sh      = d >> am1;
        r.carry = nz & sh[0];
      end
      3'b011: begin
        r.data  = d << a;
        sh      = d << am1;
        r.carry = nz & sh[N-1];
      end
      3'b100: begin
        r.data  = $signed(d) >>> a;
        sh      = d >> am1;
        r.carry = nz & sh[0];
      end
      default: begin
        r.err   = 1'b1;
        r.carry = 1'b0;
        r.data  = d;
      end
    endcase
    return r;
  endfunction

  logic          s1_valid_r;
  logic [N-1:0]  s1_data_r;
  logic [SW-1:0] s1_amt_r;
  logic [2:0]    s1_op_r;
  logic          s2_valid_r;
  logic [N-1:0]  s2_data_r;
  logic          s2_carry_r;
  logic          s2_zero_r;
  logic          s2_err_r;
  logic          s1_adv_s;
  logic          s2_adv_s;
  res_t          res_s;

  assign s2_adv_s     = ~s2_valid_r | bus.out_ready;
  assign s1_adv_s     = ~s1_valid_r | s2_adv_s;
  assign bus.in_ready = s1_adv_s;

  // Result datapath from the S1 operands
  always_comb begin
    res_s = compute(s1_data_r, s1_amt_r, s1_op_r);
  end

  // S1 operand stage
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s1_data_r  <= {N{1'b0}};
      s1_amt_r   <= {SW{1'b0}};
      s1_op_r    <= 3'b000;
    end else if (s1_adv_s) begin
      s1_valid_r <= bus.in_valid;
      if (bus.in_valid) begin
        s1_data_r <= bus.in_data;
        s1_amt_r  <= bus.in_amt;
        s1_op_r   <= bus.in_op;
      end
    end
  end

  // S2 result stage; holds steady while the consumer stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_r <= 1'b0;
      s2_data_r  <= {N{1'b0}};
      s2_carry_r <= 1'b0;
      s2_zero_r  <= 1'b0;
      s2_err_r   <= 1'b0;
    end else if (s2_adv_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_data_r  <= res_s.data;
        s2_carry_r <= res_s.carry;
        s2_zero_r  <= (res_s.data == {N{1'b0}});
        s2_err_r   <= res_s.err;
      end
    end
  end

  assign bus.out_valid = s2_valid_r;
  assign bus.out_data  = s2_data_r;
  assign bus.out_carry = s2_carry_r;
  assign bus.out_zero  = s2_zero_r;
  assign bus.out_err   = s2_err_r;

endmodule

// File: tb/tb_shift_rotate_unit.sv
// Directed and scoreboarded checks of shift_rotate_unit at N=16.
// All steps start and end just after a rising edge; outputs are sampled mid-cycle.
module tb_shift_rotate_unit;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  a;
    logic [2:0]  op;
  } beat_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;
  int   n_out;
  beat_t       pending[$];
  logic [18:0] sb[$];

  shift_rotate_if #(.N(16), .SW(4)) bus ();

  shift_rotate_unit #(.N(16), .SW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bit-by-bit reference: {err, zero, carry, data}
  function automatic logic [18:0] model(input logic [15:0] d, input logic [3:0] a,
                                        input logic [2:0] op);
    logic [15:0] r;
    logic        c;
    int          ai;
    ai = int'(a);
    r  = d;
    c  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      case (op)
        3'd0:    r[i] = d[(i + ai) % 16];
        3'd1:    r[i] = d[(i + 16 - ai) % 16];
        3'd2:    r[i] = (i + ai < 16) ? d[i + ai] : 1'b0;
        3'd3:    r[i] = (i >= ai) ? d[i - ai] : 1'b0;
        3'd4:    r[i] = (i + ai < 16) ? d[i + ai] : d[15];
        default: r[i] = d[i];
      endcase
    end
    if (ai != 0) begin
      case (op)
        3'd0:       c = r[15];
        3'd1:       c = r[0];
        3'd2, 3'd4: c = d[ai - 1];
        3'd3:       c = d[16 - ai];
        default:    c = 1'b0;
      endcase
    end
    return {(op > 3'd4), (r == 16'h0000), c, r};
  endfunction

  // One isolated beat with hand-computed expectation {err, zero, carry, data}
  task automatic single(input string tag, input logic [15:0] d, input logic [3:0] a,
                        input logic [2:0] op, input logic [18:0] exp);
    bus.in_data   = d;
    bus.in_amt    = a;
    bus.in_op     = op;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #4;
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    #4;
    chk({tag, "_not_yet"}, bus.out_valid, 0);
    @(posedge clk); #4;
    chk({tag, "_valid"}, bus.out_valid, 1);
    chk({tag, "_result"}, {bus.out_err, bus.out_zero, bus.out_carry, bus.out_data}, exp);
    @(posedge clk); #1;
  endtask

  // Offer pending beats, consume results; mode 0: stall, 1: ready, 2: random ready
  task automatic run(input int max_cycles, input int mode, output int cycles);
    cycles = 0;
    while (cycles < max_cycles && (pending.size() != 0 || sb.size() != 0)) begin
      bus.out_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : (mode == 1);
      if (pending.size() != 0) begin
        bus.in_valid = 1'b1;
        bus.in_data  = pending[0].d;
        bus.in_amt   = pending[0].a;
        bus.in_op    = pending[0].op;
      end else begin
        bus.in_valid = 1'b0;
      end
      #4;
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          chk("stream_result", {bus.out_err, bus.out_zero, bus.out_carry, bus.out_data},
              sb.pop_front());
          n_out++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(model(pending[0].d, pending[0].a, pending[0].op));
        void'(pending.pop_front());
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      cycles++;
    end
  endtask

  initial begin
    int    cyc;
    int    n0;
    beat_t b;
    logic [15:0] held;
    clk = 1'b0; reset = 1'b1; n_cmp = 0; n_bad = 0; n_out = 0;
    bus.in_valid = 1'b0; bus.in_data = 16'h0000; bus.in_amt = 4'd0;
    bus.in_op = 3'd0; bus.out_ready = 1'b0;

    // Reset state
    @(posedge clk); @(posedge clk); #4;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 16'h0000);
    chk("rst_flags", {bus.out_err, bus.out_zero, bus.out_carry}, 3'b000);
    chk("rst_in_ready", bus.in_ready, 1);
    reset = 1'b0;
    @(posedge clk); #1;

    // Single operations
    single("ror_1",   16'h0001, 4'd1,  3'd0, {1'b0, 1'b0, 1'b1, 16'h8000});
    single("rol_4",   16'h8001, 4'd4,  3'd1, {1'b0, 1'b0, 1'b0, 16'h0018});
    single("lsl_1",   16'h8001, 4'd1,  3'd3, {1'b0, 1'b0, 1'b1, 16'h0002});
    single("lsr_4",   16'h00F0, 4'd4,  3'd2, {1'b0, 1'b0, 1'b0, 16'h000F});
    single("asr_15",  16'h8000, 4'd15, 3'd4, {1'b0, 1'b0, 1'b0, 16'hFFFF});
    single("lsr_zero",16'h0001, 4'd1,  3'd2, {1'b0, 1'b1, 1'b1, 16'h0000});
    single("ror_0",   16'hA5A5, 4'd0,  3'd0, {1'b0, 1'b0, 1'b0, 16'hA5A5});
    single("illegal", 16'h1234, 4'd3,  3'd7, {1'b1, 1'b0, 1'b0, 16'h1234});
    single("legal_after", 16'h1234, 4'd4, 3'd3, {1'b0, 1'b0, 1'b1, 16'h2340});

    // Backpressure: two beats fit, the third waits
    for (int i = 0; i < 3; i++) begin
      b.d = 16'h1111 * 16'(i + 1); b.a = 4'(i + 3); b.op = 3'(i);
      pending.push_back(b);
    end
    run(2, 0, cyc);
    held = sb[0][15:0];
    chk("bp_hold_early", bus.out_data, held);
    run(2, 0, cyc);
    chk("bp_accepted", pending.size(), 1);
    bus.in_valid = 1'b1; bus.in_data = pending[0].d;
    bus.in_amt = pending[0].a; bus.in_op = pending[0].op;
    #4;
    chk("bp_in_ready", bus.in_ready, 0);
    chk("bp_hold_late", bus.out_data, held);
    @(posedge clk); #1;
    run(20, 1, cyc);
    chk("bp_drain_cycles", cyc, 3);

    // Streaming 32 beats, every op and amount
    for (int i = 0; i < 32; i++) begin
      b.d = 16'($urandom); b.a = 4'(i % 16); b.op = 3'(i % 5);
      pending.push_back(b);
    end
    run(100, 1, cyc);
    chk("stream_cycles", cyc, 34);

    // Reset with both stages full
    for (int i = 0; i < 2; i++) begin
      b.d = 16'hFFFF; b.a = 4'(i + 1); b.op = 3'd1;
      pending.push_back(b);
    end
    run(2, 0, cyc);
    chk("full_before_reset", bus.in_ready, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    #4;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_out_data", bus.out_data, 16'h0000);
    chk("mid_rst_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #4;
      chk("no_stale_beat", bus.out_valid, 0);
    end
    @(posedge clk); #1;

    // Random backpressure, 200 beats including illegal ops
    for (int i = 0; i < 200; i++) begin
      b.d = 16'($urandom); b.a = 4'($urandom_range(0, 15)); b.op = 3'($urandom_range(0, 7));
      pending.push_back(b);
    end
    n0 = n_out;
    run(3000, 2, cyc);
    chk("random_drained", pending.size() + sb.size(), 0);
    chk("random_count", n_out - n0, 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
